// File: rtl/spi_byte_phy_if.sv
// Byte-side handshake between spi_byte_phy and the downstream protocol state machine.
// SPI_BYTE_PHY_UNDERRUN_EN adds the sticky tx_underrun flag.
interface spi_byte_phy_if;
    logic [7:0] rx_data;
    logic       rx_stb;
    logic [7:0] tx_data;
    logic       tx_stb;
`ifdef SPI_BYTE_PHY_UNDERRUN_EN
    logic       tx_underrun;
`endif

    modport master (
        input  rx_data,
        input  rx_stb,
`ifdef SPI_BYTE_PHY_UNDERRUN_EN
        input  tx_underrun,
`endif
        output tx_data,
        output tx_stb
    );

    modport slave (
        output rx_data,
        output rx_stb,
`ifdef SPI_BYTE_PHY_UNDERRUN_EN
        output tx_underrun,
`endif
        input  tx_data,
        input  tx_stb
    );
endinterface

// File: rtl/spi_byte_phy.sv
// SPI mode-0 peripheral byte transceiver, MSB first, oversampled in the clk domain.
// Optional sticky underrun flag enabled by SPI_BYTE_PHY_UNDERRUN_EN.
module spi_byte_phy (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           spi_sck,
    input  logic           spi_csn,
    input  logic           spi_sdi,
    output logic           spi_sdo,
    spi_byte_phy_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_SEL} state_t;

    state_t     state;
    logic [2:0] sck_sync;
    logic [2:0] csn_sync;
    logic [1:0] sdi_sync;
    logic       sck_rise;
    logic       sck_fall;
    logic       csn_fall;
    logic       csn_rise;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] tx_buf;
    logic       tx_valid;
    logic       byte_done;
    logic [2:0] bit_cnt;
    logic [7:0] load_byte;

    // A tx_stb in the same cycle as a load bypasses the buffer entirely.
    assign load_byte = bus.tx_stb ? bus.tx_data : (tx_valid ? tx_buf : 8'h00);

    // tx_shift is zeroed whenever deselected, so its MSB is already the pin value.
    assign spi_sdo = tx_shift[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= 3'b000;
            csn_sync <= 3'b111;
            sdi_sync <= 2'b00;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            csn_fall <= 1'b0;
            csn_rise <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[1:0], spi_sck};
            csn_sync <= {csn_sync[1:0], spi_csn};
            sdi_sync <= {sdi_sync[0], spi_sdi};
            sck_rise <= sck_sync[1] & ~sck_sync[2];
            sck_fall <= ~sck_sync[1] & sck_sync[2];
            csn_fall <= ~csn_sync[1] & csn_sync[2];
            csn_rise <= csn_sync[1] & ~csn_sync[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_buf      <= '0;
            tx_valid    <= 1'b0;
            byte_done   <= 1'b0;
            bit_cnt     <= '0;
            bus.rx_data <= '0;
            bus.rx_stb  <= 1'b0;
`ifdef SPI_BYTE_PHY_UNDERRUN_EN
            bus.tx_underrun <= 1'b0;
`endif
        end else begin
            bus.rx_stb <= 1'b0;
            // NOTE: later non-blocking assignments in this block override this
            // default queue update, which is how loads and csn rise win over tx_stb.
            if (bus.tx_stb) begin
                tx_buf   <= bus.tx_data;
                tx_valid <= 1'b1;
            end

            if (csn_fall) begin
                state     <= ST_SEL;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                tx_shift  <= load_byte;
                tx_valid  <= 1'b0;
`ifdef SPI_BYTE_PHY_UNDERRUN_EN
                bus.tx_underrun <= 1'b0;
`endif
            end else if (csn_rise) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
                tx_valid  <= 1'b0;
                tx_shift  <= '0;
            end else if (state == ST_SEL) begin
                if (sck_rise) begin
                    rx_shift <= {rx_shift[5:0], sdi_sync[1]};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        bus.rx_data <= {rx_shift, sdi_sync[1]};
                        bus.rx_stb  <= 1'b1;
                        byte_done   <= 1'b1;
                    end
                end else if (sck_fall) begin
                    if (byte_done) begin
                        tx_shift  <= load_byte;
                        tx_valid  <= 1'b0;
                        byte_done <= 1'b0;
`ifdef SPI_BYTE_PHY_UNDERRUN_EN
                        if (!tx_valid && !bus.tx_stb) bus.tx_underrun <= 1'b1;
`endif
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule
